// File: rtl/sd_loader_pkg.sv
// Shared definitions for the SD sector loader: FSM states, sector geometry
// and the block-address helper.
package sd_loader_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned BYTE_CNT_W   = $clog2(SECTOR_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StIssue,
        StRecv,
        StDrain,
        StNext,
        StDone,
        StErr
    } loader_state_e;

    // SDHC cards take a sector index; byte-addressed cards take sector * 512.
    function automatic logic [31:0] block_address(input logic [31:0] sector,
                                                  input logic        byte_addr);
        return byte_addr ? {sector[22:0], 9'd0} : sector;
    endfunction

endpackage

// File: rtl/sd_loader_watchdog.sv
// Per-sector watchdog: counts enabled cycles since the last clear and flags
// expiry once the limit is reached. Saturates so expiry stays asserted.
module sd_loader_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 32'd16777216
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    // Cycle counter, cleared between sectors and held once expired
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/sd_sector_loader.sv
// Copies a run of SD sectors into byte-wide memory. Each sector is requested
// from the SD controller, streamed through a one-byte buffer into memory and
// retried from its start address on an early end or a watchdog timeout.
module sd_sector_loader
    import sd_loader_pkg::*;
#(
    parameter int unsigned MEM_AW      = 24,
    parameter int unsigned BYTE_ADDR   = 0,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 32'd16777216
) (
    input  logic              clk,
    input  logic              reset_n,
    // Host
    input  logic              start,
    input  logic [31:0]       start_sector,
    input  logic [15:0]       num_sectors,
    input  logic [MEM_AW-1:0] mem_base,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       sectors_left,
    // SD controller
    output logic              sd_rd,
    output logic [31:0]       sd_address,
    input  logic              sd_ready,
    input  logic [7:0]        sd_dout,
    input  logic              sd_byte_available,
    // Memory
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    input  logic              mem_ready
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [BYTE_CNT_W-1:0] LastByte = BYTE_CNT_W'(SECTOR_BYTES - 1);

    loader_state_e           state;
    logic [31:0]             sector;
    logic [MEM_AW-1:0]       sector_base;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic [RETRY_W-1:0]      retry;
    logic                    sd_rd_q;
    logic                    avail_prev;
    logic                    ready_prev;

    logic                    avail_rise;
    logic                    ready_rise;
    logic                    ready_fall;
    logic                    wd_enable;
    logic                    wd_clear;
    logic                    wd_expired;
    logic                    fail;

    sd_loader_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Previous-value registers for edge detection on controller handshakes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avail_prev <= 1'b0;
            ready_prev <= 1'b0;
        end else begin
            avail_prev <= sd_byte_available;
            ready_prev <= sd_ready;
        end
    end

    // Edge decode, watchdog control and failure detection
    always_comb begin
        avail_rise = sd_byte_available && !avail_prev;
        ready_rise = sd_ready && !ready_prev;
        ready_fall = !sd_ready && ready_prev;
        wd_enable  = (state == StIssue) || (state == StRecv) || (state == StDrain);
        wd_clear   = !wd_enable || ((state == StIssue) && ready_fall);
        fail       = ((state == StRecv) && ready_rise) || (wd_enable && wd_expired);
    end

    // An idle controller treats a high sd_rd as a new read, so mask it
    // whenever the controller is ready outside the request phase.
    assign sd_rd = sd_rd_q &&
                   !(sd_ready && !((state == StWaitRdy) || (state == StIssue)));

    // Main sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= StIdle;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            sectors_left <= '0;
            sd_rd_q      <= 1'b0;
            sd_address   <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            sector       <= '0;
            sector_base  <= '0;
            byte_cnt     <= '0;
            retry        <= '0;
        end else begin
            done <= 1'b0;
            if (fail) begin
                // Abandon the sector and rewind so the retry rewrites it whole
                sd_rd_q  <= 1'b0;
                mem_we   <= 1'b0;
                mem_addr <= sector_base;
                if (retry == RETRY_W'(MAX_RETRY)) begin
                    state <= StErr;
                end else begin
                    retry <= retry + RETRY_W'(1);
                    state <= StWaitRdy;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            error <= 1'b0;
                            if (num_sectors != 16'd0) begin
                                sector       <= start_sector;
                                sectors_left <= num_sectors;
                                mem_addr     <= mem_base;
                                sector_base  <= mem_base;
                                retry        <= '0;
                                busy         <= 1'b1;
                                state        <= StWaitRdy;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    StWaitRdy: begin
                        if (sd_ready) begin
                            sd_address <= block_address(sector, BYTE_ADDR != 0);
                            sd_rd_q    <= 1'b1;
                            state      <= StIssue;
                        end
                    end
                    StIssue: begin
                        if (ready_fall) begin
                            byte_cnt <= '0;
                            state    <= StRecv;
                        end
                    end
                    StRecv: begin
                        if (mem_we) begin
                            // Buffer full: controller is paused until the write lands
                            if (mem_ready) begin
                                mem_we   <= 1'b0;
                                mem_addr <= mem_addr + MEM_AW'(1);
                                byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                                sd_rd_q  <= 1'b1;
                                if (byte_cnt == LastByte) begin
                                    state <= StDrain;
                                end
                            end
                        end else if (avail_rise) begin
                            mem_data <= sd_dout;
                            mem_we   <= 1'b1;
                            sd_rd_q  <= 1'b0;
                        end
                    end
                    StDrain: begin
                        if (!sd_byte_available) begin
                            sd_rd_q <= 1'b0;
                            if (sd_ready) begin
                                state <= StNext;
                            end
                        end
                    end
                    StNext: begin
                        sectors_left <= sectors_left - 16'd1;
                        sector       <= sector + 32'd1;
                        sector_base  <= mem_addr;
                        retry        <= '0;
                        state        <= (sectors_left == 16'd1) ? StDone : StWaitRdy;
                    end
                    StDone: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                    StErr: begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        sd_rd_q <= 1'b0;
                        state   <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed bench for sd_sector_loader: SD controller model, byte memory model
// and hand-derived expectations for each load scenario.
module tb_sd_sector_loader;

    localparam int unsigned AW = 12;
    localparam int MemSize = 4096;

    localparam int MIdle  = 0;
    localparam int MGap   = 1;
    localparam int MWait  = 2;
    localparam int MHold  = 3;
    localparam int MTail  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;

    logic          start = 1'b0;
    logic [31:0]   start_sector = '0;
    logic [15:0]   num_sectors = '0;
    logic [AW-1:0] mem_base = '0;
    logic          busy, done, error;
    logic [15:0]   sectors_left;
    logic          sd_rd;
    logic [31:0]   sd_address;
    logic          sd_ready = 1'b1;
    logic [7:0]    sd_dout = '0;
    logic          sd_byte_available = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic          mem_ready = 1'b1;

    // Second instance for the byte-addressed mode; controller held ready.
    logic          reset_b = 1'b0;
    logic          start_b = 1'b0;
    logic          busy_b, done_b, error_b, sd_rd_b, mem_we_b;
    logic [15:0]   sectors_left_b;
    logic [31:0]   sd_address_b;
    logic [AW-1:0] mem_addr_b;
    logic [7:0]    mem_data_b;

    int            n_checks = 0;
    int            n_fail = 0;

    logic [7:0]    mem [MemSize];
    int            wr_cnt = 0;
    int            done_cnt = 0;
    int            mark_idx = -1;
    logic [AW-1:0] mark_addr = '0;
    logic          rd_seen = 1'b0;
    logic [31:0]   addr_q [$];
    int            fail_left = 0;

    always #5 clk = ~clk;

    sd_sector_loader #(
        .MEM_AW      (AW),
        .BYTE_ADDR   (0),
        .MAX_RETRY   (3),
        .TIMEOUT_CYC (20000)
    ) u_dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .start_sector      (start_sector),
        .num_sectors       (num_sectors),
        .mem_base          (mem_base),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .sectors_left      (sectors_left),
        .sd_rd             (sd_rd),
        .sd_address        (sd_address),
        .sd_ready          (sd_ready),
        .sd_dout           (sd_dout),
        .sd_byte_available (sd_byte_available),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .mem_we            (mem_we),
        .mem_ready         (mem_ready)
    );

    sd_sector_loader #(
        .MEM_AW      (AW),
        .BYTE_ADDR   (1),
        .MAX_RETRY   (3),
        .TIMEOUT_CYC (20000)
    ) u_dut_b (
        .clk               (clk),
        .reset_n           (reset_b),
        .start             (start_b),
        .start_sector      (32'd3),
        .num_sectors       (16'd1),
        .mem_base          ('0),
        .busy              (busy_b),
        .done              (done_b),
        .error             (error_b),
        .sectors_left      (sectors_left_b),
        .sd_rd             (sd_rd_b),
        .sd_address        (sd_address_b),
        .sd_ready          (1'b1),
        .sd_dout           (8'h00),
        .sd_byte_available (1'b0),
        .mem_addr          (mem_addr_b),
        .mem_data          (mem_data_b),
        .mem_we            (mem_we_b),
        .mem_ready         (1'b1)
    );

    function automatic logic [7:0] pat(input logic [31:0] s, input int i);
        logic [7:0] r;
        r = s[7:0] * 8'd13 + 8'(i) + 8'(i >> 8) * 8'd29;
        return r ^ 8'hA5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SD controller model: one block per read, each byte held several cycles,
    // next byte only offered while sd_rd is high. Optionally ends early.
    initial begin
        int m_st;
        int m_idx;
        int m_cnt;
        logic [31:0] m_sector;
        logic m_abort;
        m_st = MIdle;
        m_idx = 0;
        m_cnt = 0;
        m_sector = '0;
        m_abort = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_st = MIdle;
                sd_ready = 1'b1;
                sd_byte_available = 1'b0;
            end else begin
                case (m_st)
                    MIdle: begin
                        sd_ready = 1'b1;
                        sd_byte_available = 1'b0;
                        if (sd_rd) begin
                            addr_q.push_back(sd_address);
                            m_sector = sd_address;
                            m_abort = (fail_left > 0);
                            if (fail_left > 0) fail_left--;
                            sd_ready = 1'b0;
                            m_idx = 0;
                            m_cnt = 2;
                            m_st = MGap;
                        end
                    end
                    MGap: begin
                        if (m_cnt > 0) m_cnt--;
                        else m_st = MWait;
                    end
                    MWait: begin
                        if ((m_abort && m_idx == 200) || m_idx == 512) begin
                            m_cnt = 3;
                            m_st = MTail;
                        end else if (sd_rd) begin
                            sd_dout = pat(m_sector, m_idx);
                            sd_byte_available = 1'b1;
                            m_cnt = 3;
                            m_st = MHold;
                        end
                    end
                    MHold: begin
                        if (m_cnt > 0) begin
                            m_cnt--;
                        end else begin
                            sd_byte_available = 1'b0;
                            m_idx++;
                            m_cnt = 1;
                            m_st = MGap;
                        end
                    end
                    MTail: begin
                        sd_byte_available = 1'b0;
                        if (m_cnt > 0) begin
                            m_cnt--;
                        end else begin
                            sd_ready = 1'b1;
                            m_st = MIdle;
                        end
                    end
                    default: m_st = MIdle;
                endcase
            end
        end
    end

    // Memory and status monitor, sampled after the drivers have settled
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_we && mem_ready) begin
                mem[mem_addr] = mem_data;
                if (wr_cnt == mark_idx) mark_addr = mem_addr;
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (sd_rd) rd_seen = 1'b1;
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < MemSize; i++) mem[i] = 8'h00;
        wr_cnt = 0;
        done_cnt = 0;
        rd_seen = 1'b0;
        mark_idx = -1;
        addr_q.delete();
    endtask

    task automatic do_start(input logic [31:0] sec, input logic [15:0] num,
                            input logic [AW-1:0] base);
        start_sector = sec;
        num_sectors = num;
        mem_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (wr_cnt < target) check_eq({tag, "_timeout"}, 32'(wr_cnt), 32'(target));
    endtask

    task automatic check_data(input string tag, input logic [31:0] sec, input int base,
                              input int n);
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            e = pat(sec + 32'(i / 512), i % 512);
            if (mem[(base + i) % MemSize] !== e) bad++;
        end
        check_eq(tag, 32'(bad), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
        check_eq({tag, "_sd_rd"}, 32'(sd_rd), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_left"}, 32'(sectors_left), 32'd0);
        check_eq({tag, "_sd_addr"}, sd_address, 32'd0);
        check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // Two sectors from 0x100 into 0x000
        clear_stats();
        do_start(32'h100, 16'd2, 12'h000);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_left", 32'(sectors_left), 32'd2);
        wait_idle(12000, "t1");
        repeat (3) @(negedge clk);
        check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t1_error", 32'(error), 32'd0);
        check_eq("t1_writes", 32'(wr_cnt), 32'd1024);
        check_eq("t1_reads", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() == 2) begin
            check_eq("t1_addr0", addr_q[0], 32'h100);
            check_eq("t1_addr1", addr_q[1], 32'h101);
        end
        check_eq("t1_left_end", 32'(sectors_left), 32'd0);
        check_data("t1_data", 32'h100, 0, 1024);

        // Byte-addressed mode: sector 3 -> 0x600
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t2_sd_addr", sd_address_b, 32'h600);
        check_eq("t2_sd_rd", 32'(sd_rd_b), 32'd1);
        check_eq("t2_busy", 32'(busy_b), 32'd1);
        reset_b = 1'b0;

        // Memory stall at byte 100, destination wrapping past the top
        clear_stats();
        do_start(32'h20, 16'd1, 12'hF00);
        wait_writes(100, 6000, "t3_pre");
        mem_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t3_stall_rd", 32'(sd_rd), 32'd0);
        check_eq("t3_stall_we", 32'(mem_we), 32'd1);
        check_eq("t3_stall_writes", 32'(wr_cnt), 32'd100);
        mem_ready = 1'b1;
        wait_idle(6000, "t3");
        repeat (3) @(negedge clk);
        check_eq("t3_writes", 32'(wr_cnt), 32'd512);
        check_eq("t3_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t3_mem_addr_wrap", 32'(mem_addr), 32'h100);
        check_data("t3_data", 32'h20, 'hF00, 512);

        // One early end after 200 bytes: retried from the sector start
        clear_stats();
        fail_left = 1;
        mark_idx = 200;
        do_start(32'h40, 16'd1, 12'h400);
        wait_idle(10000, "t4");
        repeat (3) @(negedge clk);
        check_eq("t4_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t4_error", 32'(error), 32'd0);
        check_eq("t4_writes", 32'(wr_cnt), 32'd712);
        check_eq("t4_rewind_addr", 32'(mark_addr), 32'h400);
        check_eq("t4_reads", 32'(addr_q.size()), 32'd2);
        check_data("t4_data", 32'h40, 'h400, 512);

        // MAX_RETRY+1 early ends: error, no done
        clear_stats();
        fail_left = 4;
        do_start(32'h41, 16'd1, 12'h000);
        wait_idle(12000, "t5");
        repeat (3) @(negedge clk);
        check_eq("t5_error", 32'(error), 32'd1);
        check_eq("t5_done_cnt", 32'(done_cnt), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_sd_rd", 32'(sd_rd), 32'd0);
        check_eq("t5_reads", 32'(addr_q.size()), 32'd4);
        fail_left = 0;

        // Zero sectors: immediate done, no read, error cleared
        clear_stats();
        do_start(32'h55, 16'd0, 12'h000);
        check_eq("t6_done_pulse", 32'(done), 32'd1);
        check_eq("t6_error_clr", 32'(error), 32'd0);
        @(negedge clk);
        check_eq("t6_done_low", 32'(done), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("t6_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t6_no_rd", 32'(rd_seen), 32'd0);

        // Reset during byte 300, then a clean load afterwards
        clear_stats();
        do_start(32'h50, 16'd2, 12'h200);
        wait_writes(300, 6000, "t7_pre");
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t7_rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_stats();
        do_start(32'h60, 16'd1, 12'h800);
        wait_idle(6000, "t7");
        repeat (3) @(negedge clk);
        check_eq("t7_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t7_writes", 32'(wr_cnt), 32'd512);
        check_data("t7_data", 32'h60, 'h800, 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/sd_sector_loader.md
SD_SECTOR_LOADER -- requirements
Module: sd_sector_loader

Interface
REQ-001 SHALL have parameters: MEM_AW, default 24, memory address width; BYTE_ADDR, default 0, 0 = sd_address is sector index (SDHC), 1 = sector<<9; MAX_RETRY, default 3, retries per sector; TIMEOUT_CYC, default 2^24, per-sector watchdog in clk cycles.
REQ-002 SHALL have ports: clk  in  1  system clock; reset_n  in  1  synchronous active-low reset.
REQ-003 SHALL have host ports: start  in  1  pulse, begin load; start_sector  in  32  first SD sector; num_sectors  in  16  sectors to load (0 = none); mem_base  in  MEM_AW  first destination byte.
REQ-004 SHALL have status ports: busy  out  1  load in progress; done  out  1  one-cycle pulse on success; error  out  1  sticky until next start; sectors_left  out  16  remaining count.
REQ-005 SHALL have controller ports: sd_rd  out  1  read request/flow control; sd_address  out  32  block address; sd_ready  in  1  controller idle; sd_dout  in  8  read byte; sd_byte_available  in  1  byte valid level.
REQ-006 SHALL have memory ports: mem_addr  out  MEM_AW  write address; mem_data  out  8  write data; mem_we  out  1  write request; mem_ready  in  1  write accepted when high with mem_we.

Function
REQ-007 SHALL implement states IDLE, WAIT_RDY, ISSUE, RECV, DRAIN, NEXT, DONE, ERR.
REQ-008 IDLE: start with num_sectors!=0 SHALL latch inputs, clear error, set busy, go WAIT_RDY; start with num_sectors==0 SHALL pulse done next cycle without touching sd_rd.
REQ-009 WAIT_RDY: on sd_ready=1 SHALL drive sd_address (sector or sector<<9 per BYTE_ADDR), assert sd_rd, go ISSUE.
REQ-010 ISSUE: on sd_ready falling SHALL go RECV with byte count 0 and watchdog cleared; sd_rd held high.
REQ-011 RECV: a rising edge of sd_byte_available (registered previous-value compare) SHALL load sd_dout into a one-byte buffer and set mem_we.
REQ-012 While the buffer is full, sd_rd SHALL be low (controller pauses); buffer clears, mem_addr increments by 1 and byte count increments on the cycle mem_we&&mem_ready.
REQ-013 After the 512th byte is accepted SHALL reassert sd_rd and go DRAIN; DRAIN SHALL drop sd_rd on sd_byte_available falling, then wait sd_ready=1, then go NEXT.
REQ-014 sd_rd SHALL never be high while sd_ready=1 outside WAIT_RDY/ISSUE (prevents spurious second read).
REQ-015 NEXT: decrement sectors_left, increment sector, reset retry count; sectors_left==0 -> DONE (done pulse, busy low, IDLE), else WAIT_RDY.
REQ-016 Failure = sd_ready rising in RECV with count<512, or watchdog reaching TIMEOUT_CYC in ISSUE/RECV/DRAIN; SHALL drop sd_rd, rewind mem_addr to sector start, increment retry, go WAIT_RDY.
REQ-017 Failure with retry==MAX_RETRY SHALL go ERR: error=1, busy=0, sd_rd=0, then IDLE.
REQ-018 start while busy SHALL be ignored; mem_addr SHALL wrap modulo 2^MEM_AW.

Reset
REQ-019 reset_n=0 at a clk edge SHALL set state IDLE, busy/done/error/sd_rd/mem_we=0, sectors_left=0, sd_address=0, mem_addr=0, buffer empty, counters 0.
REQ-020 Reset mid-load SHALL abort without completing any pending memory write; recovery of the controller is its own reset's duty.

Structure
REQ-021 Shared package sd_loader_pkg SHALL hold the state enum and SECTOR_BYTES=512.
REQ-022 Watchdog counter SHALL be sub-module sd_loader_watchdog (clear, enable, expired); rest in one module, 120-400 lines.

Verification
REQ-023 Bench SHALL use a controller model with sd_byte_available held several clk per byte and pausing while sd_rd=0.
REQ-024 start_sector=0x100, num_sectors=2, mem_base=0, mem_ready=1 -> sd_address 0x100 then 0x101, 1024 writes to 0x000-0x3FF matching pattern, one done pulse, error=0.
REQ-025 BYTE_ADDR=1, start_sector=3 -> sd_address=0x600.
REQ-026 mem_ready low 10 cycles at byte 100 -> sd_rd low during stall, no lost/duplicate byte, 512 writes.
REQ-027 Model returns ready after 200 bytes once -> retry, rewritten from mem_base, done; MAX_RETRY+1 failures -> error=1, done never pulses.
REQ-028 num_sectors=0 -> done pulse, zero sd_rd; reset_n low at byte 300 -> all outputs at reset values next cycle.
